// File: rtl/br_eval.sv
// br_eval: three-state evaluator for BR instructions with branch statistics
module br_eval #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [15:0]      ir,
    input  logic [15:0]      pc,
    input  logic [2:0]       cc,
    output logic             busy,
    output logic             ben,
    output logic             done,
    output logic             ld_pc,
    output logic [15:0]      pc_next,
    output logic [CNT_W-1:0] br_cnt,
    output logic [CNT_W-1:0] taken_cnt
);
    typedef enum logic [1:0] {IDLE, EVAL, COMMIT} state_t;
    state_t state, state_nxt;
    logic [2:0] mask_q;
    logic [8:0] off_q;
    logic [15:0] pc_q;
    logic [2:0] cc_q;
    logic unused;
    assign unused = ^ir[15:12];
    // state register; reset aborts any evaluation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end
    // next state and the strobes decoded from the current state
    always_comb begin
        state_nxt = (state == IDLE) ? (start ? EVAL : IDLE) : (state == EVAL) ? COMMIT : IDLE;
        busy = state != IDLE;
        done = state == COMMIT;
        ld_pc = (state == COMMIT) && ben;
    end
    // capture on accept, evaluate in EVAL, count in COMMIT
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mask_q <= '0;
            off_q <= '0;
            pc_q <= '0;
            cc_q <= '0;
            ben <= 1'b0;
            pc_next <= '0;
            br_cnt <= '0;
            taken_cnt <= '0;
        end else begin
            if (state == IDLE && start) begin
                mask_q <= ir[11:9];
                off_q <= ir[8:0];
                pc_q <= pc;
                cc_q <= cc;
            end
            if (state == EVAL) begin
                ben <= |(mask_q & cc_q);
                pc_next <= pc_q + {{7{off_q[8]}}, off_q};
            end
            if (state == COMMIT) begin
                br_cnt <= br_cnt + CNT_W'(1);
                if (ben) taken_cnt <= taken_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_br_eval.sv
// tb_br_eval: scoreboard bench for br_eval with 4-bit counters
module tb_br_eval;
    logic clk = 0, rst_n = 0, start = 0;
    logic [15:0] ir = 0, pc = 0;
    logic [2:0] cc = 0;
    logic busy, ben, done, ld_pc;
    logic [15:0] pc_next;
    logic [3:0] br_cnt, taken_cnt;
    typedef struct {logic ben; logic [15:0] tgt; int cyc;} exp_t;
    exp_t q[$];
    exp_t e;
    int checks = 0, errors = 0, cyc = 0, n_done = 0, n_push = 0;
    logic [3:0] br_m = 0, tk_m = 0;

    br_eval #(.CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ir(ir), .pc(pc), .cc(cc),
        .busy(busy), .ben(ben), .done(done), .ld_pc(ld_pc), .pc_next(pc_next),
        .br_cnt(br_cnt), .taken_cnt(taken_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] i, input logic [15:0] p, input logic [2:0] c);
        exp_t r;
        r.ben = |(i[11:9] & c);
        r.tgt = p + {{7{i[8]}}, i[8:0]};
        r.cyc = 0;
        return r;
    endfunction

    always @(negedge clk) begin
        chk("ld_pc_without_done", {31'b0, ld_pc & ~done}, 0);
        if (done) begin
            n_done++;
            chk("sb_nonempty", {31'b0, q.size() != 0}, 1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("ben", {31'b0, ben}, {31'b0, e.ben});
                chk("ld_pc", {31'b0, ld_pc}, {31'b0, e.ben});
                chk("pc_next", {16'b0, pc_next}, {16'b0, e.tgt});
                chk("busy_in_commit", {31'b0, busy}, 1);
                chk("latency", cyc, e.cyc);
                chk("br_cnt", {28'b0, br_cnt}, {28'b0, br_m});
                chk("taken_cnt", {28'b0, taken_cnt}, {28'b0, tk_m});
                br_m = br_m + 4'd1;
                if (e.ben) tk_m = tk_m + 4'd1;
            end
        end
    end

    task automatic req(input logic [15:0] i, input logic [15:0] p, input logic [2:0] c,
                       input logic eb, input logic [15:0] et);
        int n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_idle", {31'b0, busy}, 0);
        ir = i; pc = p; cc = c; start = 1;
        q.push_back('{eb, et, cyc + 2});
        n_push++;
        @(negedge clk);
        start = 0; ir = 16'($urandom); pc = 16'($urandom); cc = 3'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain", q.size(), 0);
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_busy"}, {31'b0, busy}, 0);
        chk({tag, "_done"}, {31'b0, done}, 0);
        chk({tag, "_ld_pc"}, {31'b0, ld_pc}, 0);
        chk({tag, "_ben"}, {31'b0, ben}, 0);
        chk({tag, "_pc_next"}, {16'b0, pc_next}, 0);
        chk({tag, "_br_cnt"}, {28'b0, br_cnt}, 0);
        chk({tag, "_taken_cnt"}, {28'b0, taken_cnt}, 0);
    endtask

    initial begin
        exp_t m;
        logic [15:0] ri, rp;
        logic [2:0] rc;
        repeat (2) @(negedge clk);
        chk_reset("rst");
        rst_n = 1;
        req(16'h0E05, 16'h3001, 3'b010, 1'b1, 16'h3006);
        drain();
        chk("taken_after_fwd", {28'b0, taken_cnt}, 1);
        chk("br_after_fwd", {28'b0, br_cnt}, 1);
        req(16'h0800, 16'h3000, 3'b001, 1'b0, 16'h3000);
        req(16'h03FF, 16'h0000, 3'b001, 1'b1, 16'hFFFF);
        drain();
        chk("ben_hold", {31'b0, ben}, 1);
        chk("pc_next_hold", {16'b0, pc_next}, 32'hFFFF);
        chk("taken_after_wrap", {28'b0, taken_cnt}, 2);
        req(16'h0E00, 16'h1234, 3'b000, 1'b0, 16'h1234);
        req(16'h0000, 16'h4000, 3'b111, 1'b0, 16'h4000);
        drain();
        chk("ben_hold_zero", {31'b0, ben}, 0);
        for (int k = 0; k < 20; k++) begin
            ri = 16'($urandom); rp = 16'($urandom); rc = 3'($urandom);
            m = model(ri, rp, rc);
            req(ri, rp, rc, m.ben, m.tgt);
        end
        drain();
        ir = 16'h0810; pc = 16'h5000; cc = 3'b100; start = 1;
        q.push_back('{1'b1, 16'h5010, cyc + 2});
        n_push++;
        @(negedge clk);
        ir = 16'h0200; cc = 3'b001; start = 1;
        @(negedge clk);
        cc = 3'b010; start = 1;
        @(negedge clk);
        start = 0;
        drain();
        chk("drop_busy", {31'b0, busy}, 0);
        chk("drop_br_cnt", {28'b0, br_cnt}, {28'b0, br_m});
        ir = 16'h0E05; pc = 16'h1000; cc = 3'b010; start = 1;
        @(negedge clk);
        start = 1; rst_n = 0;
        @(negedge clk);
        chk_reset("midop");
        br_m = 0; tk_m = 0;
        rst_n = 1; start = 0;
        @(negedge clk);
        chk("start_in_rst_ignored", {31'b0, busy}, 0);
        @(negedge clk);
        chk("start_in_rst_no_done", {31'b0, done}, 0);
        for (int k = 0; k < 16; k++) begin
            rp = 16'($urandom);
            req(16'h0E01, rp, 3'b100, 1'b1, rp + 16'd1);
        end
        drain();
        chk("wrap_br_cnt", {28'b0, br_cnt}, 0);
        chk("wrap_taken_cnt", {28'b0, taken_cnt}, 0);
        chk("done_total", n_done, n_push);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
